button_reset_gen: RTL and testbench
===================================

Name: button_reset_gen

Overview:
Generates a clean reset request from a raw, bouncing push-button, for use by the game's reset path and other button consumers.
- The output feeds the asynchronous-assert / synchronous-release reset synchronizer.
- Synchronizes the raw input and debounces it with a counter FSM.
- Emits a debounced level, single-cycle press/release pulses, and a fixed-length stretched reset request.

Parameters:
DB_CYCLES, 500000, consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz); legal range >= 2.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.
STRETCH_CYCLES, 16, length in clocks of rst_req per accepted press; legal range >= 1.
STR_W, 5, stretch counter width; must satisfy 2^STR_W > STRETCH_CYCLES.

Ports:
clock  input  1  system clock; all state on posedge.
reset  input  1  reset, asynchronous, active-high; clock clock.
btn_in  input  1  raw push-button, asynchronous to clock, may bounce.
btn_level  output  1  debounced button level, registered.
press  output  1  one-clock pulse on accepted 0->1 transition.
release  output  1  one-clock pulse on accepted 1->0 transition.
rst_req  output  1  active-high reset request, STRETCH_CYCLES clocks long.

Behaviour:
Reset:
- reset=1 asynchronously clears: sync flops s1/s2, debounce counter, stretch counter, btn_level, press, release, rst_req. FSM goes to IDLE_LOW.
- Reset asserted mid-debounce or mid-stretch aborts immediately; no partial pulse is emitted after deassertion.

Synchronizer:
- Two flops: s1 <= btn_in; s2 <= s1.
- Only s2 is used downstream.

FSM (states IDLE_LOW, WAIT_HIGH, HOLD_HIGH, WAIT_LOW):
- IDLE_LOW: if s2=1, go to WAIT_HIGH and clear cnt to 0.
- WAIT_HIGH: if s2=0, return to IDLE_LOW (bounce rejected, no outputs). Else if cnt = DB_CYCLES-1, go to HOLD_HIGH, set btn_level<=1, press<=1. Else cnt<=cnt+1.
- HOLD_HIGH: if s2=0, go to WAIT_LOW and clear cnt to 0.
- WAIT_LOW: if s2=1, return to HOLD_HIGH. Else if cnt = DB_CYCLES-1, go to IDLE_LOW, set btn_level<=0, release<=1. Else cnt<=cnt+1.

Pulses:
- press and release are high for exactly one clock.
- They default to 0 every cycle and are never high together.

Latency:
- Counting the first clock edge that samples btn_in stably high as edge 0, btn_level and press rise after edge DB_CYCLES+2. Release is symmetric.

Stretcher:
- When the FSM sets press, in the same edge rst_req<=1 and scnt<=STRETCH_CYCLES-1.
- While rst_req=1 and no new press: if scnt=0, rst_req<=0; else scnt<=scnt-1.
- rst_req is therefore high for exactly STRETCH_CYCLES clocks, rising on the same edge as press.
- A new press while rst_req=1 reloads scnt, extending the request; no gap is produced.

Boundary cases:
- Glitch: any s2 excursion shorter than DB_CYCLES samples produces no output change.
- Button already held at reset release: press is detected after the normal debounce latency.
- Counter never exceeds DB_CYCLES-1 and never wraps.

Test Plan:
1. DB_CYCLES=4, STRETCH_CYCLES=3. Reset, then btn_in=1 held from edge 0 -> btn_level=1 and press=1 after edge 6, press=0 after edge 7. rst_req=1 after edges 6..8, 0 after edge 9.
2. DB_CYCLES=4: btn_in high for 3 clocks, then low -> btn_level, press, release and rst_req stay 0 throughout.
3. Bounce: btn_in toggles 1,0,1,0,1 each clock, then holds 1 -> exactly one press, 6 edges after the start of the stable hold.
4. From HOLD_HIGH, btn_in=0 held -> release=1 for one clock, 6 edges after the sampling edge. btn_level goes 0 on the same edge; rst_req unaffected.
5. Assert reset while in WAIT_HIGH with cnt=2, and again while rst_req=1 -> all outputs 0 immediately (asynchronously). After deassertion with btn_in=1 held, press occurs after the full DB_CYCLES+2 latency.
6. Random bounce stress: btn_in bursts of random length < DB_CYCLES between long stable periods -> scoreboard shows press/release strictly alternate, never coincide, and each rst_req pulse is exactly STRETCH_CYCLES long.

Source files
------------

// File: rtl/button_reset_gen.sv
// Push-button conditioner: two-flop synchronizer, counter-based debounce FSM,
// one-clock press/release pulses and a stretched reset request.
module button_reset_gen #(
  parameter int DB_CYCLES      = 500000,
  parameter int CNT_W          = 20,
  parameter int STRETCH_CYCLES = 16,
  parameter int STR_W          = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press,
  output logic       release_pulse,
  output logic       rst_req,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HOLD_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [STR_W-1:0] SCNT_LOAD = STR_W'(STRETCH_CYCLES - 1);

  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STR_W-1:0] scnt_q, scnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rst_req_q, rst_req_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      scnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rst_req_q <= 1'b0;
    end else begin
      s1_q      <= btn_in;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scnt_q    <= scnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      rst_req_q <= rst_req_d;
    end
  end

  // Debounce: a level is accepted only after the counter reaches CNT_LAST
  // without s2 reverting; any reversion drops back to the stable state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HOLD_HIGH;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = HOLD_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_LOW;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
  end

  // Stretcher: a press (re)loads the down-counter, so overlapping presses
  // extend the request without a gap.
  always_comb begin
    rst_req_d = rst_req_q;
    scnt_d    = scnt_q;
    if (press_d) begin
      rst_req_d = 1'b1;
      scnt_d    = SCNT_LOAD;
    end else if (rst_req_q) begin
      if (scnt_q == '0) begin
        rst_req_d = 1'b0;
      end else begin
        scnt_d = scnt_q - STR_W'(1);
      end
    end
  end

  assign btn_level     = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign rst_req       = rst_req_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_button_reset_gen.sv
// Directed bench for button_reset_gen with DB_CYCLES=4, STRETCH_CYCLES=3,
// plus a bounded bounce-stress phase checked against an expected-pulse queue.
module tb_button_reset_gen;

  localparam int DB  = 4;
  localparam int STR = 3;

  logic       clock;
  logic       reset;
  logic       btn_in;
  logic       btn_level;
  logic       press;
  logic       release_pulse;
  logic       rst_req;
  logic [1:0] dbg_state;

  int n_cmp;
  int n_err;

  button_reset_gen #(
    .DB_CYCLES     (DB),
    .CNT_W         (3),
    .STRETCH_CYCLES(STR),
    .STR_W         (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press        (press),
    .release_pulse(release_pulse),
    .rst_req      (rst_req),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic lvl, input logic p,
                            input logic r, input logic rq);
    check({tag, "_level"}, btn_level, lvl);
    check({tag, "_press"}, press, p);
    check({tag, "_release"}, release_pulse, r);
    check({tag, "_rst_req"}, rst_req, rq);
  endtask

  // scoreboard for the stress phase: 1 = press expected, 0 = release expected
  logic [0:0] exp_q[$];
  logic       mon_en;
  int         rst_run;

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (press || release_pulse) begin
        check("stress_no_overlap", {31'd0, press & release_pulse}, 32'd0);
        if (exp_q.size() == 0) begin
          check("stress_unexpected_pulse", 32'd1, 32'd0);
        end else begin
          check("stress_pulse_kind", {31'd0, press}, {31'd0, exp_q.pop_front()});
        end
      end
      if (rst_req) begin
        rst_run++;
      end else if (rst_run != 0) begin
        check("stress_rst_len", rst_run, STR);
        rst_run = 0;
      end
    end
  end

  logic any_out;
  logic prev_lvl;
  logic val;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    mon_en  = 1'b0;
    rst_run = 0;
    btn_in  = 1'b0;
    reset   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_state", dbg_state, 2'd0);
    tick();
    reset = 1'b0;

    // 1: clean press, latency DB+2 edges, stretch STR clocks
    tick();
    btn_in = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      if (e == 5) check_outs("t1_e5", 1'b0, 1'b0, 1'b0, 1'b0);
      if (e == 6) check_outs("t1_e6", 1'b1, 1'b1, 1'b0, 1'b1);
      if (e == 7) check_outs("t1_e7", 1'b1, 1'b0, 1'b0, 1'b1);
      if (e == 8) check_outs("t1_e8", 1'b1, 1'b0, 1'b0, 1'b1);
      if (e == 9) check_outs("t1_e9", 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // 2: short high glitch is rejected
    btn_in = 1'b0;
    do_reset();
    btn_in = 1'b1;
    any_out = 1'b0;
    for (int e = 0; e < 15; e++) begin
      if (e == 3) btn_in = 1'b0;
      tick();
      any_out = any_out | btn_level | press | release_pulse | rst_req;
    end
    check("t2_glitch_quiet", {31'd0, any_out}, 32'd0);

    // 3: bounce 1,0,1,0 then hold 1: one press 6 edges into the hold
    do_reset();
    for (int i = 0; i < 4; i++) begin
      btn_in = (i % 2 == 0);
      tick();
    end
    btn_in = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) check("t3_e5_press", {31'd0, press}, 32'd0);
      if (e == 6) check("t3_e6_press", {31'd0, press}, 32'd1);
    end
    any_out = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      any_out = any_out | press;
    end
    check("t3_single_press", {31'd0, any_out}, 32'd0);
    check("t3_hold_state", dbg_state, 2'd2);

    // 4: release from HOLD_HIGH
    btn_in = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e == 5) check_outs("t4_e5", 1'b1, 1'b0, 1'b0, 1'b0);
      if (e == 6) check_outs("t4_e6", 1'b0, 1'b0, 1'b1, 1'b0);
      if (e == 7) check_outs("t4_e7", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 5: reset mid-debounce and mid-stretch
    btn_in = 1'b1;
    for (int e = 0; e <= 4; e++) tick();
    check("t5_wait_high", dbg_state, 2'd1);
    reset = 1'b1;
    #1;
    check("t5_abort_state", dbg_state, 2'd0);
    check_outs("t5_abort1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e == 5) check("t5_e5_press", {31'd0, press}, 32'd0);
      if (e == 6) check_outs("t5_e6", 1'b1, 1'b1, 1'b0, 1'b1);
    end
    check_outs("t5_e7", 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_outs("t5_abort2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) check_outs("t5b_e5", 1'b0, 1'b0, 1'b0, 1'b0);
      if (e == 6) check_outs("t5b_e6", 1'b1, 1'b1, 1'b0, 1'b1);
    end

    // 6: random bounce bursts between long stable periods
    btn_in = 1'b0;
    do_reset();
    for (int e = 0; e < 4; e++) tick();
    prev_lvl = 1'b0;
    rst_run  = 0;
    mon_en   = 1'b1;
    for (int k = 0; k < 16; k++) begin
      int blen;
      int slen;
      blen = $urandom_range(1, DB - 1);
      for (int b = 0; b < blen; b++) begin
        btn_in = 1'($urandom_range(0, 1));
        tick();
      end
      val = 1'($urandom_range(0, 1));
      if (val != prev_lvl) exp_q.push_back(val);
      prev_lvl = val;
      btn_in   = val;
      slen = $urandom_range(12, 20);
      for (int s = 0; s < slen; s++) tick();
    end
    for (int e = 0; e < 12; e++) tick();
    mon_en = 1'b0;
    check("stress_queue_drained", exp_q.size(), 0);
    check("stress_final_level", {31'd0, btn_level}, {31'd0, prev_lvl});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
